// File: rtl/board_reset_ctrl_pkg.sv
// board_reset_ctrl_pkg: FSM state encoding, default timing constants and counter sizing helper.
package board_reset_ctrl_pkg;

    typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} state_t;

    localparam int DEF_DEBOUNCE_CYCLES    = 300000;
    localparam int DEF_LOCK_HOLD_CYCLES   = 1024;
    localparam int DEF_RST_STRETCH_CYCLES = 16;
    localparam int DEF_NUM_RST            = 2;
    localparam int DEF_STAGGER_CYCLES     = 4;
    localparam int DEF_HEARTBEAT_CYCLES   = 15000000;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/board_reset_ctrl_if.sv
// board_reset_ctrl_if: board-side inputs and domain reset/status outputs of the reset controller.
interface board_reset_ctrl_if import board_reset_ctrl_pkg::*; #(
    parameter int NUM_RST = DEF_NUM_RST
);
    logic               btn_ni;
    logic               pll_lock_i;
    logic [NUM_RST-1:0] rst_o;
    logic               ready_o;
    logic               led_o;
    logic               lock_lost_o;

    modport master (input btn_ni, pll_lock_i, output rst_o, ready_o, led_o, lock_lost_o);
    modport slave  (output btn_ni, pll_lock_i, input rst_o, ready_o, led_o, lock_lost_o);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a per-bit reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Shift the asynchronous input through two stages; q is usable after the second edge.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) {q, meta} <= {RST_VAL, RST_VAL};
        else         {q, meta} <= {meta, d};
endmodule

// File: rtl/board_reset_ctrl.sv
// board_reset_ctrl: qualifies PLL lock and button, then releases domain resets in a staggered order.
module board_reset_ctrl import board_reset_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int LOCK_HOLD_CYCLES   = DEF_LOCK_HOLD_CYCLES,
    parameter int RST_STRETCH_CYCLES = DEF_RST_STRETCH_CYCLES,
    parameter int NUM_RST            = DEF_NUM_RST,
    parameter int STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
    parameter int HEARTBEAT_CYCLES   = DEF_HEARTBEAT_CYCLES
) (
    input logic                clk_i,
    input logic                rst_ni,
    board_reset_ctrl_if.master bus
);
    localparam int REL_MAX = (NUM_RST - 1) * STAGGER_CYCLES;
    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam int LW = cnt_w(LOCK_HOLD_CYCLES);
    localparam int SW = cnt_w(RST_STRETCH_CYCLES);
    localparam int RW = cnt_w(REL_MAX);
    localparam int HW = cnt_w(HEARTBEAT_CYCLES);

    logic [1:0]         sync_q;
    logic               btn_s, lock_s;
    state_t             state_q, state_d;
    logic               deb_q, deb_d;
    logic [DW-1:0]      deb_cnt_q, deb_cnt_d;
    logic [LW-1:0]      lock_cnt_q, lock_cnt_d;
    logic [SW-1:0]      stretch_cnt_q, stretch_cnt_d;
    logic [RW-1:0]      rel_cnt_q, rel_cnt_d;
    logic [HW-1:0]      hb_cnt_q, hb_cnt_d;
    logic [NUM_RST-1:0] rst_q, rst_d;
    logic               ready_q, ready_d, led_q, led_d, lost_q, lost_d;
    logic               deb_done, lock_qual, exit_req, rel_go, hb_done;
    int                 rel_r;

    // Button idles released (1), lock idles unlocked (0).
    sync_2ff #(.WIDTH(2), .RST_VAL(2'b10)) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d     ({bus.btn_ni, bus.pll_lock_i}),
        .q     (sync_q)
    );

    assign btn_s     = sync_q[1];
    assign lock_s    = sync_q[0];
    assign deb_done  = int'(deb_cnt_q) + 1 >= DEBOUNCE_CYCLES;
    assign lock_qual = int'(lock_cnt_q) == LOCK_HOLD_CYCLES;
    assign exit_req  = state_q != HOLD && (!lock_s || !deb_q);
    assign hb_done   = int'(hb_cnt_q) + 1 >= HEARTBEAT_CYCLES;
    // Release position after this edge; leaving STRETCH is position 0, where rst_o[0] drops.
    assign rel_r     = (state_q == STRETCH) ? 0 : int'(rel_cnt_q) + 1;
    assign rel_go    = state_q == RELEASE ||
                       (state_q == STRETCH && int'(stretch_cnt_q) + 1 >= RST_STRETCH_CYCLES);

    // Debounce: follow the synced button only after an unbroken run of disagreeing cycles.
    always_comb begin
        deb_d     = (btn_s != deb_q && deb_done) ? btn_s : deb_q;
        deb_cnt_d = (btn_s != deb_q && !deb_done) ? deb_cnt_q + 1'b1 : '0;
    end

    // Sequencer: any loss of lock or button press drops everything back to HOLD, lock loss taking precedence.
    always_comb begin
        state_d       = state_q;
        rst_d         = rst_q;
        ready_d       = ready_q;
        led_d         = led_q;
        lost_d        = lost_q;
        lock_cnt_d    = !lock_s ? '0 : lock_qual ? lock_cnt_q : lock_cnt_q + 1'b1;
        stretch_cnt_d = '0;
        rel_cnt_d     = '0;
        hb_cnt_d      = '0;
        if (exit_req) begin
            state_d    = HOLD;
            rst_d      = '1;
            ready_d    = 1'b0;
            led_d      = 1'b0;
            lock_cnt_d = '0;
            lost_d     = lost_q | (state_q == RUN && !lock_s);
        end else if (state_q == HOLD) begin
            state_d = (lock_qual && deb_q) ? STRETCH : HOLD;
        end else if (rel_go) begin
            for (int k = 0; k < NUM_RST; k++)
                if (rel_r >= k * STAGGER_CYCLES) rst_d[k] = 1'b0;
            state_d   = (rel_r >= REL_MAX) ? RUN : RELEASE;
            ready_d   = rel_r >= REL_MAX;
            rel_cnt_d = (rel_r >= REL_MAX) ? '0 : RW'(rel_r);
        end else if (state_q == STRETCH) begin
            stretch_cnt_d = stretch_cnt_q + 1'b1;
        end else begin
            led_d    = hb_done ? ~led_q : led_q;
            hb_cnt_d = hb_done ? '0 : hb_cnt_q + 1'b1;
        end
    end

    // State and output registers; reset forces all domains into reset immediately.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q       <= HOLD;
            deb_q         <= 1'b1;
            deb_cnt_q     <= '0;
            lock_cnt_q    <= '0;
            stretch_cnt_q <= '0;
            rel_cnt_q     <= '0;
            hb_cnt_q      <= '0;
            rst_q         <= '1;
            ready_q       <= 1'b0;
            led_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            stretch_cnt_q <= stretch_cnt_d;
            rel_cnt_q     <= rel_cnt_d;
            hb_cnt_q      <= hb_cnt_d;
            rst_q         <= rst_d;
            ready_q       <= ready_d;
            led_q         <= led_d;
            lost_q        <= lost_d;
        end

    assign bus.rst_o       = rst_q;
    assign bus.ready_o     = ready_q;
    assign bus.led_o       = led_q;
    assign bus.lock_lost_o = lost_q;
endmodule

// File: tb/tb_board_reset_ctrl.sv
// tb_board_reset_ctrl: scoreboard bench; expected output changes are queued, a monitor matches each change.
module tb_board_reset_ctrl;
    typedef struct {
        int         c;
        logic [5:0] v;
    } ev_t;

    logic       clk    = 1'b0;
    logic       rst_ni = 1'b1;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    logic [5:0] prev   = 6'b000111;
    logic [5:0] outs;
    int         e0, s, r, x;

    board_reset_ctrl_if #(.NUM_RST(3)) bus_if ();

    board_reset_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .LOCK_HOLD_CYCLES  (8),
        .RST_STRETCH_CYCLES(3),
        .NUM_RST           (3),
        .STAGGER_CYCLES    (2),
        .HEARTBEAT_CYCLES  (5)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus_if)
    );

    assign outs = {bus_if.lock_lost_o, bus_if.led_o, bus_if.ready_o, bus_if.rst_o};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the outputs must match the next queued event, value and edge.
    always @(negedge clk) begin
        ev_t e;
        if (outs !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc %0d got %b", cyc, outs);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || e.v !== outs) begin
                    errors++;
                    $display("FAIL out_event got %b at edge %0d, expected %b at edge %0d", outs, cyc, e.v, e.c);
                end
            end
            prev = outs;
        end
    end

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input logic lost, input logic led, input logic rdy, input logic [2:0] rst);
        exp_q.push_back('{c, {lost, led, rdy, rst}});
    endtask

    task automatic release_seq(input int st, input logic lost);
        expect_ev(st + 3, lost, 1'b0, 1'b0, 3'b110);
        expect_ev(st + 5, lost, 1'b0, 1'b0, 3'b100);
        expect_ev(st + 7, lost, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic run_leds(input int run, input int ex, input logic lost);
        logic led = 1'b0;
        for (int t = run + 5; t < ex; t += 5) begin
            led = ~led;
            expect_ev(t, lost, led, 1'b1, 3'b000);
        end
    endtask

    initial begin
        bus_if.btn_ni     = 1'b1;
        bus_if.pll_lock_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1 checks++;
        if (outs !== 6'b000111) begin
            errors++;
            $display("FAIL reset_state got %b want %b", outs, 6'b000111);
        end
        at(2);
        rst_ni = 1'b1;
        // Power-up: lock rises, STRETCH at edge 10, releases at 13/15/17.
        at(4);
        bus_if.pll_lock_i = 1'b1;
        e0 = 5;
        s  = e0 + 10;
        release_seq(s, 1'b0);
        r = s + 7;
        // RUN: short button glitch ignored, 6-cycle press resets.
        x = r + 19;
        run_leds(r, x, 1'b0);
        expect_ev(x, 1'b0, 1'b0, 1'b0, 3'b111);
        at(r + 2);
        bus_if.btn_ni = 1'b0;
        at(r + 5);
        bus_if.btn_ni = 1'b1;
        at(r + 12);
        bus_if.btn_ni = 1'b0;
        at(r + 18);
        bus_if.btn_ni = 1'b1;
        s = r + 28;
        release_seq(s, 1'b0);
        r = s + 7;
        // RUN: lock drop is seen 3 edges later and sets the sticky flag.
        x = r + 10;
        run_leds(r, x, 1'b0);
        expect_ev(x, 1'b1, 1'b0, 1'b0, 3'b111);
        at(r + 7);
        bus_if.pll_lock_i = 1'b0;
        at(r + 12);
        bus_if.pll_lock_i = 1'b1;
        s = r + 23;
        release_seq(s, 1'b1);
        r = s + 7;
        // RUN: long press; re-release waits for the debounced button, not the lock.
        x = r + 8;
        run_leds(r, x, 1'b1);
        expect_ev(x, 1'b1, 1'b0, 1'b0, 3'b111);
        at(r + 1);
        bus_if.btn_ni = 1'b0;
        at(r + 21);
        bus_if.btn_ni = 1'b1;
        s = r + 28;
        release_seq(s, 1'b1);
        r = s + 7;
        // Drop lock, then re-lock with a one-cycle glitch at edge 5, then pulse rst_ni mid-RELEASE.
        x = r + 4;
        expect_ev(x, 1'b1, 1'b0, 1'b0, 3'b111);
        at(r + 1);
        bus_if.pll_lock_i = 1'b0;
        at(x + 2);
        bus_if.pll_lock_i = 1'b1;
        e0 = x + 3;
        expect_ev(e0 + 19, 1'b1, 1'b0, 1'b0, 3'b110);
        expect_ev(e0 + 20, 1'b0, 1'b0, 1'b0, 3'b111);
        at(e0 + 4);
        bus_if.pll_lock_i = 1'b0;
        at(e0 + 5);
        bus_if.pll_lock_i = 1'b1;
        at(e0 + 19);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        at(e0 + 22);
        rst_ni = 1'b1;
        s = e0 + 33;
        release_seq(s, 1'b0);
        r = s + 7;
        x = r + 12;
        run_leds(r, x, 1'b0);
        at(x);
        @(negedge clk);
        #1 checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d left want 0 (next at edge %0d)", exp_q.size(), exp_q[0].c);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board_reset_ctrl.md
BOARD_RESET_CTRL -- requirements
Module: board_reset_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  - DEBOUNCE_CYCLES, 300000, consecutive stable cycles to accept a button change.
  - LOCK_HOLD_CYCLES, 1024, consecutive locked cycles to qualify PLL lock.
  - RST_STRETCH_CYCLES, 16, minimum all-asserted reset hold once qualified.
  - NUM_RST, 2, number of reset outputs (domains), >=1.
  - STAGGER_CYCLES, 4, release spacing between consecutive rst_o bits.
  - HEARTBEAT_CYCLES, 15000000, LED half-period in RUN.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  - clk_i, in, 1, single clock.
  - rst_ni, in, 1, asynchronous active-low reset.
  - btn_ni, in, 1, raw active-low board button, asynchronous.
  - pll_lock_i, in, 1, raw PLL lock, asynchronous.
  - rst_o, out, NUM_RST, active-high domain resets; asynchronous assert, synchronous release.
  - ready_o, out, 1, all domains released.
  - led_o, out, 1, heartbeat.
  - lock_lost_o, out, 1, sticky: lock dropped while in RUN.

Function
REQ-003 btn_ni and pll_lock_i SHALL each pass a 2-flop synchronizer; the synced value is valid after the 2nd edge.
REQ-004 Debounced press SHALL change only after the synced button differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any agreeing cycle.
REQ-005 Lock counter SHALL increment each cycle synced lock is high, saturate at LOCK_HOLD_CYCLES, and clear to 0 the cycle synced lock is low; lock_qual = (count == LOCK_HOLD_CYCLES).
REQ-006 FSM states SHALL be HOLD, STRETCH, RELEASE and RUN.
REQ-007 HOLD: rst_o all 1; go to STRETCH on the edge where lock_qual=1 and the debounced button is released.
REQ-008 STRETCH: rst_o all 1; count RST_STRETCH_CYCLES edges, then enter RELEASE, clearing rst_o[0] on that same edge.
REQ-009 RELEASE: rst_o[k] SHALL clear k*STAGGER_CYCLES edges after rst_o[0]; once cleared, a bit stays cleared until a return to HOLD.
REQ-010 On the edge that clears rst_o[NUM_RST-1], the FSM SHALL enter RUN and set ready_o=1; for NUM_RST=1 this is the rst_o[0] edge.
REQ-011 Return to HOLD from STRETCH, RELEASE or RUN:
  - Trigger: synced lock low or debounced button pressed.
  - On the next edge, all rst_o=1, ready_o=0, and every counter except the debounce counter clears.
  - Lock loss takes priority when both triggers occur in the same cycle; the outcome is identical.
REQ-012 lock_lost_o SHALL set on a lock-loss exit from RUN only, and clear only via rst_ni.
REQ-013 led_o SHALL be 0 outside RUN; on RUN entry it is 0 and toggles every HEARTBEAT_CYCLES edges.
REQ-014 Counter widths SHALL be $clog2(param+1); every counter saturates or clears, none wraps.

Reset
REQ-015 While rst_ni=0, outputs SHALL be held asynchronously at: rst_o all 1, ready_o 0, led_o 0, lock_lost_o 0.
REQ-016 While rst_ni=0, internal state SHALL be: state HOLD, all counters 0, button synchronizer and debounced value "released" (1), lock synchronizer 0.
REQ-017 After rst_ni deasserts, the full HOLD qualification SHALL be required.

Structure
REQ-018 A shared package SHALL hold the FSM state enum and default parameter constants.
REQ-019 One sub-module, sync_2ff (parametrised width, reset value), SHALL implement REQ-003.

Verification
Bench parameters: DEBOUNCE=4, LOCK_HOLD=8, STRETCH=3, NUM_RST=3, STAGGER=2, HEARTBEAT=5. Edge 0 is the first edge after pll_lock_i rises, button released.
REQ-020 Power-up: lock rises before edge 0 -> STRETCH at edge 10; rst_o[0] falls at edge 13, rst_o[1] at 15, rst_o[2] and ready_o change at 17.
REQ-021 Lock glitch low for 1 cycle at edge 5 -> lock count restarts; rst_o[0] release is delayed by exactly the glitch offset.
REQ-022 In RUN, drop lock -> 3 edges later all rst_o=1, ready_o=0, lock_lost_o=1 (stays 1 through re-qualification).
REQ-023 In RUN, button low for 3 cycles -> no effect. Button low for 6 cycles -> reset sequence; re-release only after the button has been high 4 cycles.
REQ-024 In RUN, led_o toggles every 5 edges from 0 at RUN entry; in all other states it is constant 0.
REQ-025 rst_ni pulsed low mid-RELEASE -> outputs reach reset values immediately; lock_lost_o=0; the full sequence repeats.
